// File: rtl/kanagawa_hal_gray_ptr_rx.sv
// Destination-side receiver for a synchronized Gray pointer: decodes it, checks each
// advance against MAX_STEP, and hands out the available span via take/take_ack.
module kanagawa_hal_gray_ptr_rx #(
  parameter int WIDTH    = 8,
  parameter int MAX_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_ptr,
  input  logic             take,
  input  logic [WIDTH-1:0] take_count,
  output logic             take_ack,
  output logic [WIDTH-1:0] avail,
  output logic [WIDTH-1:0] bin_ptr,
  output logic [WIDTH-1:0] advance,
  output logic             advance_valid,
  output logic             err_step,
  input  logic             err_clear
);

  typedef enum logic [1:0] {PRIME, LOAD, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] bin_ptr_q, bin_ptr_d;
  logic [WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] avail_q, avail_d;
  logic [WIDTH-1:0] advance_q, advance_d;
  logic             advance_valid_q, advance_valid_d;
  logic             take_ack_q, take_ack_d;
  logic             err_step_q, err_step_d;
  logic [WIDTH-1:0] bin_new;
  logic [WIDTH-1:0] step;
  logic             step_bad;

  always_comb begin
    bin_new = '0;
    bin_new[WIDTH-1] = gray_q[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) bin_new[i] = bin_new[i+1] ^ gray_q[i];
  end

  assign step = bin_new - bin_ptr_q;

  always_comb begin
    state_d         = state_q;
    bin_ptr_d       = bin_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    advance_d       = '0;
    advance_valid_d = 1'b0;
    take_ack_d      = 1'b0;
    step_bad        = 1'b0;
    case (state_q)
      PRIME: state_d = LOAD;
      LOAD: begin
        // Adopt whatever the remote side already published; nothing is owed yet.
        bin_ptr_d = bin_new;
        rd_ptr_d  = bin_new;
        state_d   = RUN;
      end
      default: begin
        if (step != '0) begin
          if (step <= WIDTH'(MAX_STEP)) begin
            bin_ptr_d       = bin_new;
            advance_d       = step;
            advance_valid_d = 1'b1;
          end else begin
            step_bad = 1'b1;
          end
        end
        // Judged against registered avail so a same-edge advance cannot over-grant.
        if (take && (take_count <= avail_q)) begin
          rd_ptr_d   = rd_ptr_q + take_count;
          take_ack_d = 1'b1;
        end
      end
    endcase
    avail_d = bin_ptr_d - rd_ptr_d;
    if (step_bad)       err_step_d = 1'b1;
    else if (err_clear) err_step_d = 1'b0;
    else                err_step_d = err_step_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= PRIME;
      gray_q          <= '0;
      bin_ptr_q       <= '0;
      rd_ptr_q        <= '0;
      avail_q         <= '0;
      advance_q       <= '0;
      advance_valid_q <= 1'b0;
      take_ack_q      <= 1'b0;
      err_step_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      gray_q          <= gray_ptr;
      bin_ptr_q       <= bin_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      avail_q         <= avail_d;
      advance_q       <= advance_d;
      advance_valid_q <= advance_valid_d;
      take_ack_q      <= take_ack_d;
      err_step_q      <= err_step_d;
    end
  end

  assign take_ack      = take_ack_q;
  assign avail         = avail_q;
  assign bin_ptr       = bin_ptr_q;
  assign advance       = advance_q;
  assign advance_valid = advance_valid_q;
  assign err_step      = err_step_q;

endmodule

// File: tb/tb_kanagawa_hal_gray_ptr_rx.sv
// Bench for kanagawa_hal_gray_ptr_rx: directed scenarios plus a random walk, all
// checked cycle by cycle against an arithmetic model of the pointer receiver.
module tb_kanagawa_hal_gray_ptr_rx;
  localparam int W    = 8;
  localparam int MAXS = 1;
  localparam int MSK  = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] gray_ptr;
  logic         take;
  logic [W-1:0] take_count;
  logic         take_ack;
  logic [W-1:0] avail;
  logic [W-1:0] bin_ptr;
  logic [W-1:0] advance;
  logic         advance_valid;
  logic         err_step;
  logic         err_clear;

  kanagawa_hal_gray_ptr_rx #(.WIDTH(W), .MAX_STEP(MAXS)) dut (
    .clk(clk), .rst(rst), .gray_ptr(gray_ptr), .take(take), .take_count(take_count),
    .take_ack(take_ack), .avail(avail), .bin_ptr(bin_ptr), .advance(advance),
    .advance_valid(advance_valid), .err_step(err_step), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: edges seen since reset release, and the observable registers
  int m_edges, m_gq, m_bin, m_rd, m_avail, m_adv, m_advv, m_ack, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) & MSK;
  endfunction

  function automatic int g2b(input int g);
    int b = 0;
    for (int s = 0; s < W; s++) b ^= (g >> s);
    return b & MSK;
  endfunction

  function automatic int diff(input int a, input int b);
    return (a - b) & MSK;
  endfunction

  task automatic model_reset();
    m_edges = 0; m_gq = 0; m_bin = 0; m_rd = 0; m_avail = 0;
    m_adv = 0; m_advv = 0; m_ack = 0; m_err = 0;
  endtask

  task automatic model_edge(input int g_in, input bit tk, input int tc, input bit ec);
    int dec, st;
    bit bad = 0;
    dec = g2b(m_gq);
    m_advv = 0; m_adv = 0; m_ack = 0;
    if (m_edges == 1) begin
      m_bin = dec; m_rd = dec;
    end else if (m_edges >= 2) begin
      st = diff(dec, m_bin);
      if (st >= 1 && st <= MAXS) begin
        m_bin = dec; m_adv = st; m_advv = 1;
      end else if (st != 0) bad = 1;
      if (tk && tc <= m_avail) begin
        m_rd = (m_rd + tc) & MSK; m_ack = 1;
      end
    end
    m_avail = diff(m_bin, m_rd);
    if (bad) m_err = 1;
    else if (ec) m_err = 0;
    m_gq = g_in;
    m_edges++;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bin_ptr"}, bin_ptr, m_bin);
    chk({tag, ".avail"}, avail, m_avail);
    chk({tag, ".take_ack"}, take_ack, m_ack);
    chk({tag, ".adv_valid"}, advance_valid, m_advv);
    chk({tag, ".err_step"}, err_step, m_err);
    if (m_advv != 0) chk({tag, ".advance"}, advance, m_adv);
  endtask

  // one clock: apply inputs (binary pointer, Gray-encoded here), step model, compare
  task automatic cyc(input string tag, input int pb, input bit tk, input int tc, input bit ec);
    gray_ptr = W'(b2g(pb)); take = tk; take_count = W'(tc); err_clear = ec;
    @(posedge clk);
    model_edge(b2g(pb), tk, tc, ec);
    #1 check_all(tag);
  endtask

  task automatic do_reset(input int pb);
    gray_ptr = W'(b2g(pb)); take = 1'b0; take_count = '0; err_clear = 1'b0;
    rst = 1'b1;
    model_reset();
    #2 check_all("rst");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int cur, tc, jmp;
  bit tk, ec;

  initial begin
    rst = 1'b0;
    gray_ptr = '0; take = 1'b0; take_count = '0; err_clear = 1'b0;
    #1;
    do_reset(0);

    // load from a nonzero remote pointer
    do_reset(5);
    cyc("prime", 5, 1, 0, 0);
    cyc("load", 5, 1, 0, 0);
    chk("load_bin", bin_ptr, 8'h05);
    chk("load_avail", avail, 8'h00);

    // forward steps, then take handshake
    do_reset(0);
    cyc("prime", 0, 0, 0, 0);
    cyc("load", 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cyc("walk", i, 0, 0, 0);
    cyc("walk", 4, 0, 0, 0);
    cyc("walk", 4, 0, 0, 0);
    chk("walk_avail", avail, 8'h04);
    cyc("take_big", 4, 1, 5, 0);
    chk("take_big_ack", take_ack, 1'b0);
    cyc("take3", 4, 1, 3, 0);
    chk("take3_avail", avail, 8'h01);
    cyc("idle", 5, 0, 0, 0);
    cyc("idle", 6, 0, 0, 0);
    cyc("idle", 7, 0, 0, 0);
    cyc("idle", 7, 0, 0, 0);
    cyc("idle", 8, 0, 0, 0);
    cyc("take_adv", 8, 1, 3, 0);
    chk("take_adv_avail", avail, 8'h02);
    cyc("idle", 9, 0, 0, 0);
    cyc("idle", 9, 0, 0, 0);
    chk("pre_rst_avail", avail, 8'h03);

    // asynchronous reset mid-stream with take pending
    gray_ptr = W'(b2g(9)); take = 1'b1; take_count = 8'd1;
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    chk("async_rst_avail", avail, 8'h00);
    #3 rst = 1'b0;
    cyc("reprime", 9, 1, 1, 0);
    cyc("reload", 9, 1, 1, 0);
    chk("reload_bin", bin_ptr, 8'h09);

    // illegal jump, clear, clear-vs-set priority
    do_reset(8'h10);
    cyc("prime", 8'h10, 0, 0, 0);
    cyc("load", 8'h10, 0, 0, 0);
    cyc("jump", 8'h13, 0, 0, 0);
    cyc("jump", 8'h10, 0, 0, 0);
    chk("jump_err", err_step, 1'b1);
    chk("jump_bin", bin_ptr, 8'h10);
    cyc("back", 8'h10, 0, 0, 0);
    cyc("clear", 8'h10, 0, 0, 1);
    chk("clear_err", err_step, 1'b0);
    cyc("jump2", 8'h20, 0, 0, 1);
    cyc("jump2", 8'h10, 0, 0, 1);
    chk("set_beats_clear", err_step, 1'b1);
    cyc("back", 8'h10, 0, 0, 1);
    cyc("back", 8'h10, 0, 0, 0);

    // modulo wrap through 0xFF -> 0x00
    do_reset(8'hFC);
    cyc("prime", 8'hFC, 0, 0, 0);
    cyc("load", 8'hFD, 0, 0, 0);
    cyc("wrap", 8'hFE, 0, 0, 0);
    cyc("wrap", 8'hFF, 0, 0, 0);
    cyc("wrap", 8'h00, 0, 0, 0);
    cyc("wrap", 8'h00, 0, 0, 0);
    cyc("wrap", 8'h00, 0, 0, 0);
    chk("wrap_avail", avail, 8'h04);
    chk("wrap_err", err_step, 1'b0);
    cyc("wrap_take", 8'h00, 1, 4, 0);
    chk("wrap_take_ack", take_ack, 1'b1);
    chk("wrap_take_avail", avail, 8'h00);

    // random walk with occasional illegal jumps and random takes
    cur = $urandom_range(0, MSK);
    do_reset(cur);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 55) cur = (cur + 1) & MSK;
      jmp = cur;
      if ($urandom_range(0, 99) < 4) jmp = (cur + $urandom_range(2, MSK)) & MSK;
      tk = ($urandom_range(0, 99) < 40);
      tc = $urandom_range(0, m_avail + 2);
      ec = ($urandom_range(0, 99) < 10);
      cyc("rand", jmp, tk, tc, ec);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end
endmodule
